// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the RV32 pipeline hazard controller.
//   - Forwarding-select encodings driven onto ForwardAE/ForwardBE
//   - Mul/div sequencer state type
//   - Default mul/div occupancy latencies
//   - fwd_sel(): E-stage forwarding priority (M over W, x0 never forwarded)
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned DIV_LAT_DEF = 32;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if ((rs == rd_m) && we_m && (rs != 5'd0))      return FWD_MEM;
    else if ((rs == rd_w) && we_w && (rs != 5'd0)) return FWD_WB;
    else                                           return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// muldiv_seq: multi-cycle M-extension sequencer. Holds an op in Execute for
// exactly MUL_LAT or DIV_LAT cycles: the start cycle plus LAT-1 BUSY cycles.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_start        M-extension op valid in E (ignored while BUSY)
//   i_is_div       1 = DIV/REM class, 0 = MUL class
//   o_stall        freeze F/D/E and bubble M (mdStall)
//   o_busy         sequencer in BUSY
//   o_done         result valid in E this cycle; op advances at this edge
import hazard_ctrl_pkg::*;

module muldiv_seq #(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_stall,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 2);

  md_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = i_is_div ? DIV_INIT : MUL_INIT;
        end
      end
      BUSY: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, whatever the state.
  always_comb begin
    o_stall = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    if (!reset) begin
      o_busy = (r_state == BUSY);
      unique case (r_state)
        IDLE:    o_stall = i_start;
        BUSY: begin
          o_stall = (r_cnt != '0);
          o_done  = (r_cnt == '0);
        end
        default: o_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32 pipeline.
//   Produces stall (register hold) and flush (register clear) controls, E-stage
//   forwarding selects, and wraps the mul/div sequencer that freezes F/D/E.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   Rs1D/Rs2D                  sources in D;  Rs1E/Rs2E/RdE  regs in E
//   RdM/RdW, RegWriteM/W       writeback destinations and enables in M, W
//   ResultSrcE0                load in E;  PCSrcE  taken branch/jump in E
//   MulDivStartE/MulDivIsDivE  M-extension op in E and its class
//   ForwardAE/BE               00 RF, 10 ALUResultM, 01 ResultW
//   StallF/D/E, FlushD/E/M     pipeline register hold / clear
//   MdBusy, MdDoneE            sequencer busy, mul/div result valid in E
// Build option: define HAZARD_PERF_CNT_EN to add the saturating performance
//   counter outputs PerfStallCycles, PerfFlushCount, PerfMdOps.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MulDivStartE,
  input  logic             MulDivIsDivE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdBusy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] PerfStallCycles,
  output logic [CNT_W-1:0] PerfFlushCount,
  output logic [CNT_W-1:0] PerfMdOps,
`endif
  output logic             MdDoneE
);

  if (MUL_LAT < 2 || DIV_LAT < 2 || MUL_LAT > DIV_LAT || CNT_W < 1) begin : g_bad_params
    $error("hazard_ctrl: need 2 <= MUL_LAT <= DIV_LAT and CNT_W >= 1");
  end

  logic w_lw_stall;
  logic w_md_stall;

  muldiv_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .i_start  (MulDivStartE),
    .i_is_div (MulDivIsDivE),
    .o_stall  (w_md_stall),
    .o_busy   (MdBusy),
    .o_done   (MdDoneE)
  );

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // A load-use bubble must not clear ID/EX while the sequencer holds a
  // mul/div op there; the held D instruction simply waits behind it.
  always_comb begin
    w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!reset) begin
      StallF = w_lw_stall | w_md_stall;
      StallD = w_lw_stall | w_md_stall;
      StallE = w_md_stall;
      FlushD = PCSrcE;
      FlushE = PCSrcE | (w_lw_stall & ~w_md_stall);
      FlushM = w_md_stall;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_md_cnt    <= '0;
    end else begin
      if (StallF  && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (PCSrcE  && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (MdDoneE && (r_md_cnt    != '1)) r_md_cnt    <= r_md_cnt + 1'b1;
    end
  end

  assign PerfStallCycles = r_stall_cnt;
  assign PerfFlushCount  = r_flush_cnt;
  assign PerfMdOps       = r_md_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. A cycle-level model
// tracks how long the current mul/div op has occupied E and derives every
// output from the hazard rules; directed literal checks pin that model.
module tb_hazard_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 32;
  localparam int unsigned CNT_W   = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivStartE, MulDivIsDivE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] PerfStallCycles, PerfFlushCount, PerfMdOps;
`endif

  hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ResultSrcE0  (ResultSrcE0),
    .PCSrcE       (PCSrcE),
    .MulDivStartE (MulDivStartE),
    .MulDivIsDivE (MulDivIsDivE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .MdBusy       (MdBusy),
`ifdef HAZARD_PERF_CNT_EN
    .PerfStallCycles (PerfStallCycles),
    .PerfFlushCount  (PerfFlushCount),
    .PerfMdOps       (PerfMdOps),
`endif
    .MdDoneE      (MdDoneE)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_exp(input int rs, input int rdm, input bit wm,
                                 input int rdw, input bit ww);
    if (rs != 0 && rs == rdm && wm) return 2;
    if (rs != 0 && rs == rdw && ww) return 1;
    return 0;
  endfunction

  // Model: occupancy age of the op currently held in E and its total latency.
  bit     m_active = 1'b0;
  int     m_age    = 0;
  int     m_lat    = 0;
  longint m_pstall = 0, m_pflush = 0, m_pmd = 0;

  always @(negedge clk) begin
    bit occ, e_md, e_done, e_busy, e_lw, live;
    int cur_age, cur_lat;
    live    = !reset;
    occ     = live && (m_active || MulDivStartE);
    cur_age = m_active ? m_age : 0;
    cur_lat = m_active ? m_lat : (MulDivIsDivE ? int'(DIV_LAT) : int'(MUL_LAT));
    e_md    = occ && (cur_age < cur_lat - 1);
    e_done  = occ && (cur_age == cur_lat - 1);
    e_busy  = live && m_active;
    e_lw    = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);

    chk("ForwardAE", ForwardAE, fwd_exp(Rs1E, RdM, RegWriteM, RdW, RegWriteW));
    chk("ForwardBE", ForwardBE, fwd_exp(Rs2E, RdM, RegWriteM, RdW, RegWriteW));
    chk("StallF",  StallF,  live && (e_lw || e_md));
    chk("StallD",  StallD,  live && (e_lw || e_md));
    chk("StallE",  StallE,  e_md);
    chk("FlushD",  FlushD,  live && PCSrcE);
    chk("FlushE",  FlushE,  live && (PCSrcE || (e_lw && !e_md)));
    chk("FlushM",  FlushM,  e_md);
    chk("MdBusy",  MdBusy,  e_busy);
    chk("MdDoneE", MdDoneE, e_done);
`ifdef HAZARD_PERF_CNT_EN
    chk("PerfStallCycles", PerfStallCycles, m_pstall);
    chk("PerfFlushCount",  PerfFlushCount,  m_pflush);
    chk("PerfMdOps",       PerfMdOps,       m_pmd);
`endif

    if (!live) begin
      m_active = 1'b0;
      m_pstall = 0; m_pflush = 0; m_pmd = 0;
    end else begin
      if (e_lw || e_md) m_pstall = m_pstall + 1;
      if (PCSrcE)       m_pflush = m_pflush + 1;
      if (e_done)       m_pmd    = m_pmd + 1;
      if (occ) begin
        if (e_done) m_active = 1'b0;
        else begin
          m_active = 1'b1;
          m_age    = cur_age + 1;
          m_lat    = cur_lat;
        end
      end
    end
  end

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MulDivStartE = 0; MulDivIsDivE = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_stall, done_at;
    int pat[4];
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    #2;
    chk("reset_stallF", StallF, 0);
    chk("reset_mdbusy", MdBusy, 0);
    next_cycle();
    reset = 1'b0;

    // Forwarding priority
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #2 chk("fwd_mem", ForwardAE, 2);
    RdM = 0;
    #2 chk("fwd_wb", ForwardAE, 1);
    Rs1E = 0;
    #2 chk("fwd_x0", ForwardAE, 0);

    // Load-use
    next_cycle();
    idle_inputs();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    #2;
    chk("lw_stallF", StallF, 1);
    chk("lw_stallD", StallD, 1);
    chk("lw_flushE", FlushE, 1);
    chk("lw_stallE", StallE, 0);
    next_cycle();
    RdE = 0; Rs2D = 0;
    #2 chk("lw_x0_stallF", StallF, 0);

    // Branch with load-use
    next_cycle();
    RdE = 9; Rs1D = 9; PCSrcE = 1;
    #2;
    chk("br_flushD", FlushD, 1);
    chk("br_flushE", FlushE, 1);
    chk("br_stallF", StallF, 1);

    // DIV occupancy
    next_cycle();
    idle_inputs();
    MulDivStartE = 1; MulDivIsDivE = 1;
    n_stall = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      #2;
      if (StallF && StallD && StallE && FlushM) n_stall++;
      if (MdDoneE) begin done_at = c; break; end
      next_cycle();
    end
    chk("div_stall_cycles", n_stall, 31);
    chk("div_done_cycle", done_at, 32);
    next_cycle();
    MulDivStartE = 0;
    #2;
    chk("div_idle_busy", MdBusy, 0);
    chk("div_idle_stall", StallF, 0);

    // Back-to-back MUL
    next_cycle();
    MulDivStartE = 1; MulDivIsDivE = 0;
    for (int c = 0; c < 4; c++) begin
      #2 pat[c] = StallF;
      next_cycle();
    end
    MulDivStartE = 0;
    chk("mul_pat0", pat[0], 1);
    chk("mul_pat1", pat[1], 0);
    chk("mul_pat2", pat[2], 1);
    chk("mul_pat3", pat[3], 0);

    // DIV with load-use in D while BUSY, then reset at cnt=10 (age 21)
    next_cycle();
    MulDivStartE = 1; MulDivIsDivE = 1;
    for (int age = 1; age <= 21; age++) begin
      next_cycle();
      if (age == 5) begin
        ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
        #2;
        chk("busy_lw_flushE", FlushE, 0);
        chk("busy_lw_stallE", StallE, 1);
      end
    end
    reset = 1'b1;
    #2;
    chk("rst_busy_stallF", StallF, 0);
    chk("rst_busy_flushM", FlushM, 0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    #2;
    chk("post_rst_busy", MdBusy, 0);
    chk("post_rst_stallF", StallF, 0);
    chk("post_rst_stallE", StallE, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_rst_pstall", PerfStallCycles, 0);
    chk("post_rst_pflush", PerfFlushCount, 0);
    chk("post_rst_pmd", PerfMdOps, 0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      reset        = ($urandom_range(0, 59) == 0);
      Rs1D         = 5'($urandom_range(0, 3));
      Rs2D         = 5'($urandom_range(0, 3));
      Rs1E         = 5'($urandom_range(0, 3));
      Rs2E         = 5'($urandom_range(0, 3));
      RdE          = 5'($urandom_range(0, 3));
      RdM          = 5'($urandom_range(0, 3));
      RdW          = 5'($urandom_range(0, 3));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      ResultSrcE0  = ($urandom_range(0, 2) == 0);
      PCSrcE       = ($urandom_range(0, 7) == 0);
      MulDivStartE = ($urandom_range(0, 3) == 0);
      MulDivIsDivE = ($urandom_range(0, 3) == 0);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
